// File: rtl/acca_div16by8_pkg.sv
// Shared constants for the 16/8 restoring divider: state encoding, default widths, latency.
// APPROX_DIV_EN selects the truncated-quotient latency for DIV_LAT.
package acca_div16by8_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_N          = 8;
  localparam int DIV_TRUNC_BITS = 2;

`ifdef APPROX_DIV_EN
  localparam int DIV_LAT = DIV_N - DIV_TRUNC_BITS + 1;
`else
  localparam int DIV_LAT = DIV_N + 1;
`endif

endpackage

// File: rtl/acca_div16by8_if.sv
// Operand/result handshake bundle between the multiplier stage and the divider.
interface acca_div16by8_if
  import acca_div16by8_pkg::*;
#(
  parameter int N = DIV_N
);
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [N-1:0]   quotient;
  logic [N-1:0]   remainder;
  logic           dz;
  logic           ovf;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, dz, ovf
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, dz, ovf
  );
endinterface

// File: rtl/acca_div_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module acca_div_step
  import acca_div16by8_pkg::*;
#(
  parameter int N = DIV_N
) (
  input  logic [N-1:0] r_in,
  input  logic         din,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] r_out,
  output logic         q_bit
);
  logic [N:0] r_shift;

  always_comb begin
    r_shift = {r_in, din};
    // Compare at N+1 bits so a shifted-out MSB still counts; the difference always fits N bits.
    q_bit   = (r_shift >= {1'b0, divisor});
    r_out   = q_bit ? (r_shift[N-1:0] - divisor) : r_shift[N-1:0];
  end
endmodule

// File: rtl/acca_div16by8.sv
// Sequential 2N/N unsigned restoring divider, one quotient bit per clock, valid/ready on both sides.
// APPROX_DIV_EN stops iterating after quotient bit TRUNC_BITS (low bits forced 0).
module acca_div16by8
  import acca_div16by8_pkg::*;
#(
  parameter int N          = DIV_N,
  parameter int TRUNC_BITS = DIV_TRUNC_BITS
) (
  input logic             clk,
  input logic             rst_n,
  acca_div16by8_if.slave  bus
);
`ifdef APPROX_DIV_EN
  localparam bit APPROX = 1'b1;
`else
  localparam bit APPROX = 1'b0;
`endif
  localparam int SKIP = APPROX ? TRUNC_BITS : 0;
  localparam int CW   = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_IDX  = CW'(SKIP);
  localparam logic [CW-1:0] FIRST_IDX = CW'(N - 1);

  div_state_t    state_q, state_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  q_q, q_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  dvd_lo_q, dvd_lo_d;
  logic [N-1:0]  dvs_q, dvs_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  rem_q, rem_d;
  logic          dz_q, dz_d;
  logic          ovf_q, ovf_d;

  logic [N-1:0]  r_step;
  logic          q_step;

  acca_div_step #(.N(N)) u_step (
    .r_in    (r_q),
    .din     (dvd_lo_q[cnt_q]),
    .divisor (dvs_q),
    .r_out   (r_step),
    .q_bit   (q_step)
  );

  always_comb begin
    state_d  = state_q;
    r_d      = r_q;
    q_d      = q_q;
    cnt_d    = cnt_q;
    dvd_lo_d = dvd_lo_q;
    dvs_d    = dvs_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          // The high half seeds the partial remainder, so only the low half is kept for shifting.
          dvd_lo_d = bus.dividend[N-1:0];
          dvs_d    = bus.divisor;
          if (bus.divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = bus.dividend[N-1:0];
            dz_d    = 1'b1;
            ovf_d   = 1'b0;
          end else if (bus.dividend[2*N-1:N] >= bus.divisor) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = '0;
            dz_d    = 1'b0;
            ovf_d   = 1'b1;
          end else begin
            state_d = CALC;
            r_d     = bus.dividend[2*N-1:N];
            q_d     = '0;
            cnt_d   = FIRST_IDX;
            dz_d    = 1'b0;
            ovf_d   = 1'b0;
          end
        end
      end
      CALC: begin
        r_d        = r_step;
        q_d[cnt_q] = q_step;
        if (cnt_q == LAST_IDX) begin
          state_d = DONE;
          quo_d   = q_d;
          rem_d   = r_step;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      r_q      <= '0;
      q_q      <= '0;
      cnt_q    <= '0;
      dvd_lo_q <= '0;
      dvs_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      q_q      <= q_d;
      cnt_q    <= cnt_d;
      dvd_lo_q <= dvd_lo_d;
      dvs_q    <= dvs_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.quotient  = quo_q;
  assign bus.remainder = rem_q;
  assign bus.dz        = dz_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_acca_div16by8.sv
// Self-checking bench for acca_div16by8: directed vectors, random operands, backpressure, reset abort.
module tb_acca_div16by8;
`ifdef APPROX_DIV_EN
  localparam int TB_SKIP = 2;
`else
  localparam int TB_SKIP = 0;
`endif
  localparam int TB_LAT = 8 - TB_SKIP + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   chk_cnt = 0;
  int   pass_cnt = 0;

  always #5 clk = ~clk;

  acca_div16by8_if #(.N(8)) bus ();

  acca_div16by8 #(.N(8), .TRUNC_BITS(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference: {dz, ovf, quotient, remainder} from plain integer division.
  function automatic logic [17:0] ref_div(input logic [15:0] a, input logic [7:0] b);
    int unsigned x;
    int unsigned d;
    if (b == 8'd0) return {1'b1, 1'b0, 8'hFF, a[7:0]};
    if (a[15:8] >= b) return {1'b0, 1'b1, 8'hFF, 8'h00};
    x = 32'(a) >> TB_SKIP;
    d = 32'(b);
    return {2'b00, 8'((x / d) << TB_SKIP), 8'(x % d)};
  endfunction

  function automatic int ref_lat(input logic [15:0] a, input logic [7:0] b);
    if (b == 8'd0 || a[15:8] >= b) return 1;
    return TB_LAT;
  endfunction

  // Issues one operand pair, holds out_ready low for 'stall' cycles once the result shows, then accepts it.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b, input int stall,
                        output logic [17:0] res, output int lat, output bit stable);
    int guard;
    logic [17:0] snap;
    guard = 0;
    bus.out_ready = 1'b0;
    while (bus.in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    bus.dividend = a;
    bus.divisor  = b;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    res    = {bus.dz, bus.ovf, bus.quotient, bus.remainder};
    snap   = res;
    stable = 1'b1;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      if ({bus.dz, bus.ovf, bus.quotient, bus.remainder} !== snap ||
          bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) stable = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    $display("txn a=%h b=%h -> dz=%b ovf=%b q=%h r=%h lat=%0d stall=%0d",
             a, b, res[17], res[16], res[15:8], res[7:0], lat, stall);
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.dividend = '0; bus.divisor = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_cnt++;
    if ({bus.in_ready, bus.out_valid, bus.dz, bus.ovf} !== 4'b1000)
      $display("FAIL reset_flags got rdy/vld/dz/ovf=%b want 1000",
               {bus.in_ready, bus.out_valid, bus.dz, bus.ovf});
    else pass_cnt++;
    chk_cnt++;
    if ({bus.quotient, bus.remainder} !== 16'h0000)
      $display("FAIL reset_data got q/r=%h want 0000", {bus.quotient, bus.remainder});
    else pass_cnt++;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [15:0] va[4] = '{16'h1234, 16'hFE01, 16'h1234, 16'h5000};
    logic [7:0]  vb[4] = '{8'h56, 8'hFF, 8'h00, 8'h40};
    int          vs[4] = '{0, 0, 0, 5};
    logic [17:0] res;
    logic [17:0] exp;
    int          lat;
    bit          stable;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vs[i], res, lat, stable);
      exp = ref_div(va[i], vb[i]);
      chk_cnt++;
      if (res !== exp) $display("FAIL directed_%0d result got %h want %h", i, res, exp);
      else pass_cnt++;
      chk_cnt++;
      if (lat != ref_lat(va[i], vb[i]))
        $display("FAIL directed_%0d latency got %0d want %0d", i, lat, ref_lat(va[i], vb[i]));
      else pass_cnt++;
      chk_cnt++;
      if (stable !== 1'b1) $display("FAIL directed_%0d hold got unstable want stable", i);
      else pass_cnt++;
      if (i == 0) begin
        chk_cnt++;
        if (res[15:0] !== ((TB_SKIP == 2) ? 16'h342F : 16'h3610))
          $display("FAIL directed_plan_value got q/r=%h", res[15:0]);
        else pass_cnt++;
      end
    end
    chk_cnt++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL handshake_release got vld/rdy=%b%b want 01", bus.out_valid, bus.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_random;
    logic [15:0] a;
    logic [7:0]  b;
    int          mode;
    int          stall;
    logic [17:0] res;
    logic [17:0] exp;
    int          lat;
    bit          stable;
    for (int n = 0; n < 40; n++) begin
      b    = 8'($urandom_range(0, 255));
      mode = $urandom_range(0, 7);
      if (mode == 0) b = 8'd0;
      if (b != 8'd0 && mode != 1) a = {8'($urandom_range(0, 32'(b) - 1)), 8'($urandom)};
      else a = 16'($urandom);
      if (mode == 2) a = {a[15:8], 8'h00} & 16'h00FF;
      stall = $urandom_range(0, 3);
      run_op(a, b, stall, res, lat, stable);
      exp = ref_div(a, b);
      chk_cnt++;
      if (res !== exp || lat != ref_lat(a, b) || stable !== 1'b1)
        $display("FAIL random_%0d a=%h b=%h got %h lat %0d stable %b want %h lat %0d",
                 n, a, b, res, lat, stable, exp, ref_lat(a, b));
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a2;
    logic [7:0]  b2;
    int          cyc;
    bit          saw_ready;
    logic [17:0] got;
    b2 = 8'($urandom_range(1, 255));
    a2 = {8'($urandom_range(0, 32'(b2) - 1)), 8'($urandom)};
    bus.dividend = 16'h1234; bus.divisor = 8'h56; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.dividend = a2; bus.divisor = b2;
    cyc = 0; saw_ready = 1'b0;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      if (bus.in_ready === 1'b1) saw_ready = 1'b1;
      @(posedge clk); #1; cyc++;
    end
    got = {bus.dz, bus.ovf, bus.quotient, bus.remainder};
    chk_cnt++;
    if (saw_ready !== 1'b0 || got !== ref_div(16'h1234, 8'h56))
      $display("FAIL busy_ignore got %h ready_seen %b want %h ready_seen 0",
               got, saw_ready, ref_div(16'h1234, 8'h56));
    else pass_cnt++;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk_cnt++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL b2b_gap got rdy/vld=%b%b want 10", bus.in_ready, bus.out_valid);
    else pass_cnt++;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 1;
    while (bus.out_valid !== 1'b1 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    got = {bus.dz, bus.ovf, bus.quotient, bus.remainder};
    chk_cnt++;
    if (got !== ref_div(a2, b2) || cyc != ref_lat(a2, b2))
      $display("FAIL b2b_second a=%h b=%h got %h lat %0d want %h lat %0d",
               a2, b2, got, cyc, ref_div(a2, b2), ref_lat(a2, b2));
    else pass_cnt++;
    $display("txn a=%h b=%h -> dz=%b ovf=%b q=%h r=%h lat=%0d (b2b)",
             a2, b2, got[17], got[16], got[15:8], got[7:0], cyc);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_calc;
    bit          saw_valid;
    logic [17:0] res;
    int          lat;
    bit          stable;
    bus.dividend = 16'h1234; bus.divisor = 8'h56; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.quotient !== 8'h00)
      $display("FAIL reset_abort got vld/rdy=%b%b q=%h want 01 q=00",
               bus.out_valid, bus.in_ready, bus.quotient);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) saw_valid = 1'b1;
    end
    chk_cnt++;
    if (saw_valid !== 1'b0) $display("FAIL stale_valid got out_valid=1 want 0");
    else pass_cnt++;
    run_op(16'h00FF, 8'h01, 0, res, lat, stable);
    chk_cnt++;
    if (res !== ref_div(16'h00FF, 8'h01) || lat != TB_LAT)
      $display("FAIL post_reset_op got %h lat %0d want %h lat %0d",
               res, lat, ref_div(16'h00FF, 8'h01), TB_LAT);
    else pass_cnt++;
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_back_to_back;
    test_reset_mid_calc;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
